// File: rtl/execute_load_store_align_if.sv
// Bundled handshake/bus signals for the load-response aligner.
// master = surrounding pipeline/memory/AFE stage, slave = the aligner.
interface execute_load_store_align_if #(
    parameter int unsigned P_DEPTH_N = 2
);
    logic                 iFLUSH;
    logic                 iREQ_VALID;
    logic                 oREQ_BUSY;
    logic [1:0]           iREQ_ADDR_LOW;
    logic [1:0]           iREQ_SIZE;
    logic [3:0]           iREQ_AFE;
    logic [4:0]           iREQ_DESTINATION;
    logic                 iMEM_VALID;
    logic                 oMEM_BUSY;
    logic [31:0]          iMEM_DATA;
    logic                 oOUT_VALID;
    logic                 iOUT_BUSY;
    logic [31:0]          oOUT_DATA;
    logic [3:0]           oOUT_AFE;
    logic [4:0]           oOUT_DESTINATION;
    logic                 oOUT_FAULT;
    logic [P_DEPTH_N:0]   oPENDING_COUNT;

    modport slave (
        input  iFLUSH, iREQ_VALID, iREQ_ADDR_LOW, iREQ_SIZE, iREQ_AFE, iREQ_DESTINATION,
               iMEM_VALID, iMEM_DATA, iOUT_BUSY,
        output oREQ_BUSY, oMEM_BUSY, oOUT_VALID, oOUT_DATA, oOUT_AFE, oOUT_DESTINATION,
               oOUT_FAULT, oPENDING_COUNT
    );

    modport master (
        output iFLUSH, iREQ_VALID, iREQ_ADDR_LOW, iREQ_SIZE, iREQ_AFE, iREQ_DESTINATION,
               iMEM_VALID, iMEM_DATA, iOUT_BUSY,
        input  oREQ_BUSY, oMEM_BUSY, oOUT_VALID, oOUT_DATA, oOUT_AFE, oOUT_DESTINATION,
               oOUT_FAULT, oPENDING_COUNT
    );
endinterface

// File: rtl/execute_load_store_align.sv
// Load-response aligner: in-order pending-load queue, byte/half/word extraction with zero-extension,
// and discard of responses belonging to flushed loads. Optional misalignment fault: LDST_ALIGN_FAULT_EN.
module execute_load_store_align #(
    parameter int unsigned P_DEPTH   = 4,
    parameter int unsigned P_DEPTH_N = 2
) (
    input  logic                          iCLOCK,
    input  logic                          iRESET_SYNC,
    execute_load_store_align_if.slave     bus
);
    localparam int unsigned PTR_W  = P_DEPTH_N;
    localparam int unsigned CNT_W  = P_DEPTH_N + 1;
    // Discards can build up across repeated flushes, so give the counter headroom
    localparam int unsigned DISC_W = P_DEPTH_N + 4;

    typedef struct packed {
        logic [1:0] addr_low;
        logic [1:0] size;
        logic [3:0] afe;
        logic [4:0] dest;
    } entry_t;

    entry_t              queue_q [P_DEPTH];
    logic [PTR_W-1:0]    head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [DISC_W-1:0]   discard_q, discard_d;
    logic                out_valid_q, out_valid_d;
    logic [31:0]         out_data_q, out_data_d;
    logic [3:0]          out_afe_q, out_afe_d;
    logic [4:0]          out_dest_q, out_dest_d;
    logic                out_fault_q, out_fault_d;

    entry_t              head_entry;
    logic                full, empty, discarding;
    logic                req_busy_c, mem_busy_c;
    logic                push, accept, pop;
    logic [31:0]         aligned;
    logic                fault;

    assign head_entry = queue_q[head_q];
    assign full       = (count_q == CNT_W'(P_DEPTH));
    assign empty      = (count_q == '0);
    assign discarding = (discard_q != '0);
    assign req_busy_c = full || bus.iFLUSH;
    assign mem_busy_c = !discarding && (empty || (out_valid_q && bus.iOUT_BUSY));
    assign push       = bus.iREQ_VALID && !req_busy_c;
    assign accept     = bus.iMEM_VALID && !mem_busy_c;
    assign pop        = accept && !discarding;

    // Extract the addressed lane(s) from the raw read word
    always_comb begin
        aligned = bus.iMEM_DATA;
        case (head_entry.size)
            2'd0: begin
                case (head_entry.addr_low)
                    2'd0:    aligned = {24'h0, bus.iMEM_DATA[7:0]};
                    2'd1:    aligned = {24'h0, bus.iMEM_DATA[15:8]};
                    2'd2:    aligned = {24'h0, bus.iMEM_DATA[23:16]};
                    default: aligned = {24'h0, bus.iMEM_DATA[31:24]};
                endcase
            end
            2'd1:    aligned = head_entry.addr_low[1] ? {16'h0, bus.iMEM_DATA[31:16]}
                                                      : {16'h0, bus.iMEM_DATA[15:0]};
            default: aligned = bus.iMEM_DATA;
        endcase
    end

`ifdef LDST_ALIGN_FAULT_EN
    always_comb begin
        fault = 1'b0;
        case (head_entry.size)
            2'd0:    fault = 1'b0;
            2'd1:    fault = head_entry.addr_low[0];
            default: fault = (head_entry.addr_low != 2'd0);
        endcase
    end
`else
    assign fault = 1'b0;
`endif

    // Next-state: queue pointers, discard counter and output register
    always_comb begin
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q;
        discard_d   = discard_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_afe_d   = out_afe_q;
        out_dest_d  = out_dest_q;
        out_fault_d = out_fault_q;

        if (bus.iFLUSH) begin
            head_d      = '0;
            tail_d      = '0;
            count_d     = '0;
            discard_d   = discard_q + DISC_W'(count_q) - DISC_W'(accept);
            out_valid_d = 1'b0;
        end else begin
            head_d    = head_q + PTR_W'(pop);
            tail_d    = tail_q + PTR_W'(push);
            count_d   = count_q + CNT_W'(push) - CNT_W'(pop);
            discard_d = discard_q - DISC_W'(accept && discarding);
            if (pop) begin
                out_valid_d = 1'b1;
                out_data_d  = aligned;
                out_afe_d   = head_entry.afe;
                out_dest_d  = head_entry.dest;
                out_fault_d = fault;
            end else if (out_valid_q && !bus.iOUT_BUSY) begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC) begin
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            discard_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_afe_q   <= '0;
            out_dest_q  <= '0;
            out_fault_q <= 1'b0;
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            discard_q   <= discard_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_afe_q   <= out_afe_d;
            out_dest_q  <= out_dest_d;
            out_fault_q <= out_fault_d;
        end
    end

    // Queue storage needs no reset; validity is tracked by the pointers
    always_ff @(posedge iCLOCK) begin
        if (push) begin
            queue_q[tail_q] <= '{addr_low: bus.iREQ_ADDR_LOW, size: bus.iREQ_SIZE,
                                 afe: bus.iREQ_AFE, dest: bus.iREQ_DESTINATION};
        end
    end

    assign bus.oREQ_BUSY        = req_busy_c;
    assign bus.oMEM_BUSY        = mem_busy_c;
    assign bus.oOUT_VALID       = out_valid_q;
    assign bus.oOUT_DATA        = out_data_q;
    assign bus.oOUT_AFE         = out_afe_q;
    assign bus.oOUT_DESTINATION = out_dest_q;
    assign bus.oOUT_FAULT       = out_fault_q;
    assign bus.oPENDING_COUNT   = count_q;

endmodule

// File: tb/tb_execute_load_store_align.sv
// Directed bench for execute_load_store_align: single-load vector table plus
// full-queue, output-stall and flush/discard sequences.
module tb_execute_load_store_align;
    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

`ifdef LDST_ALIGN_FAULT_EN
    localparam bit FAULT_ON = 1'b1;
`else
    localparam bit FAULT_ON = 1'b0;
`endif

    execute_load_store_align_if #(.P_DEPTH_N(2)) bus ();

    execute_load_store_align #(.P_DEPTH(4), .P_DEPTH_N(2)) dut (
        .iCLOCK      (clk),
        .iRESET_SYNC (rst),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  size;
        logic [1:0]  addr;
        logic [3:0]  afe;
        logic [4:0]  dest;
        logic [31:0] mem;
        logic [31:0] exp;
        bit          misal;
    } vec_t;

    vec_t vecs [10];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic req(input logic [1:0] size, input logic [1:0] addr,
                       input logic [3:0] afe, input logic [4:0] dest);
        bus.iREQ_VALID       = 1'b1;
        bus.iREQ_SIZE        = size;
        bus.iREQ_ADDR_LOW    = addr;
        bus.iREQ_AFE         = afe;
        bus.iREQ_DESTINATION = dest;
    endtask

    initial begin
        vecs[0] = '{2'd0, 2'd2, 4'h1, 5'd3,  32'h11AA2233, 32'h000000AA, 1'b0};
        vecs[1] = '{2'd1, 2'd2, 4'h2, 5'd4,  32'hBEEF1234, 32'h0000BEEF, 1'b0};
        vecs[2] = '{2'd1, 2'd0, 4'h2, 5'd5,  32'hBEEF1234, 32'h00001234, 1'b0};
        vecs[3] = '{2'd0, 2'd0, 4'h3, 5'd6,  32'h11AA2233, 32'h00000033, 1'b0};
        vecs[4] = '{2'd0, 2'd3, 4'h1, 5'd7,  32'h11AA2233, 32'h00000011, 1'b0};
        vecs[5] = '{2'd0, 2'd1, 4'h1, 5'd8,  32'h11AA2233, 32'h00000022, 1'b0};
        vecs[6] = '{2'd1, 2'd3, 4'h2, 5'd9,  32'hCAFEF00D, 32'h0000CAFE, 1'b1};
        vecs[7] = '{2'd2, 2'd0, 4'h0, 5'd10, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0};
        vecs[8] = '{2'd2, 2'd1, 4'h0, 5'd11, 32'h01234567, 32'h01234567, 1'b1};
        vecs[9] = '{2'd3, 2'd2, 4'h5, 5'd31, 32'h89ABCDEF, 32'h89ABCDEF, 1'b1};

        rst = 1'b1;
        bus.iFLUSH = 1'b0;
        bus.iREQ_VALID = 1'b0;
        bus.iREQ_ADDR_LOW = '0;
        bus.iREQ_SIZE = '0;
        bus.iREQ_AFE = '0;
        bus.iREQ_DESTINATION = '0;
        bus.iMEM_VALID = 1'b0;
        bus.iMEM_DATA = '0;
        bus.iOUT_BUSY = 1'b0;
        tick();
        tick();
        chk("rst_valid", 32'(bus.oOUT_VALID), 32'd0);
        chk("rst_data",  bus.oOUT_DATA, 32'd0);
        chk("rst_afe",   32'(bus.oOUT_AFE), 32'd0);
        chk("rst_dest",  32'(bus.oOUT_DESTINATION), 32'd0);
        chk("rst_fault", 32'(bus.oOUT_FAULT), 32'd0);
        chk("rst_count", 32'(bus.oPENDING_COUNT), 32'd0);
        chk("rst_req_busy", 32'(bus.oREQ_BUSY), 32'd0);
        chk("rst_mem_busy", 32'(bus.oMEM_BUSY), 32'd1);
        rst = 1'b0;
        tick();

        // Single load per vector: push, respond, check result, let it be taken
        for (int i = 0; i < 10; i++) begin
            req(vecs[i].size, vecs[i].addr, vecs[i].afe, vecs[i].dest);
            tick();
            bus.iREQ_VALID = 1'b0;
            chk($sformatf("v%0d_count", i), 32'(bus.oPENDING_COUNT), 32'd1);
            bus.iMEM_VALID = 1'b1;
            bus.iMEM_DATA  = vecs[i].mem;
            #1;
            chk($sformatf("v%0d_mem_busy", i), 32'(bus.oMEM_BUSY), 32'd0);
            tick();
            bus.iMEM_VALID = 1'b0;
            chk($sformatf("v%0d_valid", i), 32'(bus.oOUT_VALID), 32'd1);
            chk($sformatf("v%0d_data", i),  bus.oOUT_DATA, vecs[i].exp);
            chk($sformatf("v%0d_afe", i),   32'(bus.oOUT_AFE), 32'(vecs[i].afe));
            chk($sformatf("v%0d_dest", i),  32'(bus.oOUT_DESTINATION), 32'(vecs[i].dest));
            chk($sformatf("v%0d_fault", i), 32'(bus.oOUT_FAULT), 32'(vecs[i].misal & FAULT_ON));
            tick();
            chk($sformatf("v%0d_taken", i), 32'(bus.oOUT_VALID), 32'd0);
        end

        // Fill the queue, refuse a fifth load, then free one slot
        for (int i = 0; i < 4; i++) begin
            req(2'd2, 2'd0, 4'h0, 5'(10 + i));
            tick();
        end
        bus.iREQ_VALID = 1'b0;
        #1;
        chk("full_count", 32'(bus.oPENDING_COUNT), 32'd4);
        chk("full_busy",  32'(bus.oREQ_BUSY), 32'd1);
        req(2'd2, 2'd0, 4'h0, 5'd14);
        tick();
        bus.iREQ_VALID = 1'b0;
        chk("full_refused", 32'(bus.oPENDING_COUNT), 32'd4);
        bus.iMEM_VALID = 1'b1;
        bus.iMEM_DATA  = 32'hA000_000A;
        tick();
        bus.iMEM_VALID = 1'b0;
        #1;
        chk("pop_count", 32'(bus.oPENDING_COUNT), 32'd3);
        chk("pop_busy",  32'(bus.oREQ_BUSY), 32'd0);
        chk("pop_dest",  32'(bus.oOUT_DESTINATION), 32'd10);

        // Simultaneous push and pop keeps the count
        req(2'd2, 2'd0, 4'h0, 5'd15);
        bus.iMEM_VALID = 1'b1;
        bus.iMEM_DATA  = 32'hB000_000B;
        tick();
        bus.iREQ_VALID = 1'b0;
        bus.iMEM_VALID = 1'b0;
        chk("pushpop_count", 32'(bus.oPENDING_COUNT), 32'd3);
        chk("pushpop_data",  bus.oOUT_DATA, 32'hB000_000B);
        chk("pushpop_dest",  32'(bus.oOUT_DESTINATION), 32'd11);

        // Output stall: result held, response back-pressured
        bus.iOUT_BUSY  = 1'b1;
        bus.iMEM_VALID = 1'b1;
        bus.iMEM_DATA  = 32'hC000_000C;
        #1;
        chk("stall_mem_busy", 32'(bus.oMEM_BUSY), 32'd1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("stall%0d_valid", i), 32'(bus.oOUT_VALID), 32'd1);
            chk($sformatf("stall%0d_data", i),  bus.oOUT_DATA, 32'hB000_000B);
            chk($sformatf("stall%0d_count", i), 32'(bus.oPENDING_COUNT), 32'd3);
        end
        bus.iOUT_BUSY = 1'b0;
        #1;
        chk("unstall_mem_busy", 32'(bus.oMEM_BUSY), 32'd0);
        tick();
        chk("drain12_data", bus.oOUT_DATA, 32'hC000_000C);
        chk("drain12_dest", 32'(bus.oOUT_DESTINATION), 32'd12);
        bus.iMEM_DATA = 32'hD000_000D;
        tick();
        chk("drain13_dest", 32'(bus.oOUT_DESTINATION), 32'd13);
        bus.iMEM_DATA = 32'hF000_000F;
        tick();
        bus.iMEM_VALID = 1'b0;
        chk("drain15_data",  bus.oOUT_DATA, 32'hF000_000F);
        chk("drain15_dest",  32'(bus.oOUT_DESTINATION), 32'd15);
        chk("drain_count",   32'(bus.oPENDING_COUNT), 32'd0);
        tick();
        chk("drain_valid", 32'(bus.oOUT_VALID), 32'd0);

        // Flush with a held result and three pending loads
        bus.iOUT_BUSY = 1'b1;
        req(2'd2, 2'd0, 4'h0, 5'd19);
        tick();
        bus.iREQ_VALID = 1'b0;
        bus.iMEM_VALID = 1'b1;
        bus.iMEM_DATA  = 32'h1313_1313;
        tick();
        bus.iMEM_VALID = 1'b0;
        chk("preflush_valid", 32'(bus.oOUT_VALID), 32'd1);
        for (int i = 0; i < 3; i++) begin
            req(2'd0, 2'd0, 4'h0, 5'(20 + i));
            tick();
        end
        bus.iREQ_VALID = 1'b0;
        chk("preflush_count", 32'(bus.oPENDING_COUNT), 32'd3);
        bus.iFLUSH = 1'b1;
        req(2'd0, 2'd0, 4'h0, 5'd30);
        #1;
        chk("flush_req_busy", 32'(bus.oREQ_BUSY), 32'd1);
        tick();
        bus.iFLUSH     = 1'b0;
        bus.iREQ_VALID = 1'b0;
        bus.iOUT_BUSY  = 1'b0;
        chk("flush_count", 32'(bus.oPENDING_COUNT), 32'd0);
        chk("flush_valid", 32'(bus.oOUT_VALID), 32'd0);
        req(2'd0, 2'd1, 4'h2, 5'd23);
        tick();
        bus.iREQ_VALID = 1'b0;
        chk("postflush_count", 32'(bus.oPENDING_COUNT), 32'd1);
        for (int i = 0; i < 3; i++) begin
            bus.iMEM_VALID = 1'b1;
            bus.iMEM_DATA  = 32'hFFFF_FFFF;
            #1;
            chk($sformatf("discard%0d_mem_busy", i), 32'(bus.oMEM_BUSY), 32'd0);
            tick();
            chk($sformatf("discard%0d_valid", i), 32'(bus.oOUT_VALID), 32'd0);
            chk($sformatf("discard%0d_count", i), 32'(bus.oPENDING_COUNT), 32'd1);
        end
        bus.iMEM_DATA = 32'h0000_5500;
        tick();
        bus.iMEM_VALID = 1'b0;
        chk("newload_valid", 32'(bus.oOUT_VALID), 32'd1);
        chk("newload_data",  bus.oOUT_DATA, 32'h0000_0055);
        chk("newload_dest",  32'(bus.oOUT_DESTINATION), 32'd23);
        chk("newload_count", 32'(bus.oPENDING_COUNT), 32'd0);
        tick();
        chk("idle_mem_busy", 32'(bus.oMEM_BUSY), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
